// File: rtl/gpr_writeback_arbiter_pkg.sv
// Shared constants for the GPR writeback arbiter slice: requester ids, GPR geometry,
// and the saturating-increment helper used by the optional stats counters.
package gpr_writeback_arbiter_pkg;

  typedef enum logic [1:0] {
    REQ_ALU     = 2'd0,
    REQ_LOAD    = 2'd1,
    REQ_SPECIAL = 2'd2
  } reqId_t;

  localparam int unsigned GPR_INDEX_WIDTH = 5;
  localparam int unsigned GPR_DATA_WIDTH  = 32;
  localparam int unsigned REG_ZERO        = 0;
  localparam int unsigned STAT_WIDTH      = 16;

  function automatic logic [STAT_WIDTH-1:0] satInc(input logic [STAT_WIDTH-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/gpr_writeback_arbiter_round_robin.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
// The pointer register is owned by the instantiating module.
module round_robin_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(pointer) + k) % NUM_REQ;
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Shares the GPR write port among ALU/load/special writeback with round-robin arbitration,
// a registered write stage, r0 suppression and a busy scoreboard. Stats: GPR_WRITEBACK_ARBITER_STATS_EN.
module gpr_writeback_arbiter
  import gpr_writeback_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
  localparam int unsigned IDX_W     = $clog2(REG_COUNT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            reqValid,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic [NUM_REQ*IDX_W-1:0]      reqIndex,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  input  logic                          reserveValid,
  input  logic [IDX_W-1:0]              reserveIndex,
  output logic [IDX_W-1:0]              gprIndex2,
  output logic [DATA_WIDTH-1:0]         gprWriteData2,
  output logic                          gprWriteEnable2,
  output logic [REG_COUNT-1:0]          busy
`ifdef GPR_WRITEBACK_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0] grantCount,
  output logic [STAT_WIDTH-1:0]         conflictCount
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      pointer;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      nextPointer;
  logic [NUM_REQ-1:0]    grant;
  logic                  transfer;
  logic                  writesReg;
  logic [IDX_W-1:0]      xferIndex;
  logic [DATA_WIDTH-1:0] xferData;
  logic [REG_COUNT-1:0]  busyNext;

  round_robin_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arbiter (
    .request(reqValid),
    .pointer(pointer),
    .grant  (grant),
    .winner (winner)
  );

  assign reqReady    = reset ? grant : '0;
  assign transfer    = |reqReady;
  assign nextPointer = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    xferIndex = '0;
    xferData  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        xferIndex = reqIndex[i*IDX_W +: IDX_W];
        xferData  = reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign writesReg = transfer && (xferIndex != IDX_W'(REG_ZERO));

  // Clear before set so a reservation at the retiring edge keeps the register busy.
  always_comb begin
    busyNext = busy;
    if (writesReg) begin
      busyNext[xferIndex] = 1'b0;
    end
    if (reserveValid && (reserveIndex != IDX_W'(REG_ZERO))) begin
      busyNext[reserveIndex] = 1'b1;
    end
    busyNext[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pointer         <= '0;
      gprIndex2       <= '0;
      gprWriteData2   <= '0;
      gprWriteEnable2 <= 1'b0;
      busy            <= '0;
    end else begin
      busy            <= busyNext;
      gprWriteEnable2 <= writesReg;
      if (transfer) begin
        pointer       <= nextPointer;
        gprIndex2     <= xferIndex;
        gprWriteData2 <= xferData;
      end
    end
  end

`ifdef GPR_WRITEBACK_ARBITER_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      grantCount    <= '0;
      conflictCount <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (reqReady[i]) begin
          grantCount[i*STAT_WIDTH +: STAT_WIDTH] <= satInc(grantCount[i*STAT_WIDTH +: STAT_WIDTH]);
        end
      end
      if ($countones(reqValid) > 1) begin
        conflictCount <= satInc(conflictCount);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Scoreboard bench for gpr_writeback_arbiter: a reference arbiter/scoreboard model pushes the
// expected write-stage output per edge; entries are popped and compared on the following negedge.
module tb_gpr_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  reqValid;
  logic [2:0]  reqReady;
  logic [14:0] reqIndex;
  logic [95:0] reqData;
  logic        reserveValid;
  logic [4:0]  reserveIndex;
  logic [4:0]  gprIndex2;
  logic [31:0] gprWriteData2;
  logic        gprWriteEnable2;
  logic [31:0] busy;

  always #5 clock = ~clock;

  gpr_writeback_arbiter #(
    .NUM_REQ(3),
    .REG_COUNT(32),
    .DATA_WIDTH(32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqIndex       (reqIndex),
    .reqData        (reqData),
    .reserveValid   (reserveValid),
    .reserveIndex   (reserveIndex),
    .gprIndex2      (gprIndex2),
    .gprWriteData2  (gprWriteData2),
    .gprWriteEnable2(gprWriteEnable2),
    .busy           (busy)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  idx;
    logic [31:0] data;
  } wrExp_t;

  wrExp_t      expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  mPtr = '0;
  logic [31:0] mBusy = '0;
  logic [4:0]  mIdx = '0;
  logic [31:0] mData = '0;
  bit          modelValid = 1'b0;
  logic [2:0]  expReady;
  int          expWinner;
  logic [2:0]  lastGrant = '0;
  logic [31:0] regFile[32];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic [4:0] idx, input logic [31:0] d);
    reqValid[i]          = v;
    reqIndex[i*5 +: 5]   = idx;
    reqData[i*32 +: 32]  = d;
  endtask

  task automatic calcReady();
    int i;
    expReady  = '0;
    expWinner = -1;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        i = (int'(mPtr) + k) % 3;
        if (expWinner < 0 && reqValid[i]) begin
          expWinner   = i;
          expReady[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    wrExp_t      e;
    logic        gWe;
    logic [4:0]  gIdx;
    logic [31:0] gData;
    logic [4:0]  idx;
    logic [31:0] data;
    @(negedge clock);
    calcReady();
    checkVal("reqReady", {29'b0, reqReady}, {29'b0, expReady});
    if (modelValid) checkVal("busy", busy, mBusy);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal("writeEnable", {31'b0, gprWriteEnable2}, {31'b0, e.we});
      checkVal("writeIndex", {27'b0, gprIndex2}, {27'b0, e.idx});
      checkVal("writeData", gprWriteData2, e.data);
    end
    gWe   = gprWriteEnable2;
    gIdx  = gprIndex2;
    gData = gprWriteData2;
    @(posedge clock);
    if (gWe === 1'b1) regFile[gIdx] = gData;
    if (!reset) begin
      mPtr      = '0;
      mBusy     = '0;
      mIdx      = '0;
      mData     = '0;
      lastGrant = '0;
      expQ.push_back('{we: 1'b0, idx: 5'd0, data: 32'd0});
    end else begin
      lastGrant = expReady;
      if (expWinner >= 0) begin
        idx  = reqIndex[expWinner*5 +: 5];
        data = reqData[expWinner*32 +: 32];
        if (idx != 5'd0) mBusy[idx] = 1'b0;
        mIdx  = idx;
        mData = data;
        expQ.push_back('{we: (idx != 5'd0), idx: idx, data: data});
        mPtr = 2'((expWinner + 1) % 3);
      end else begin
        expQ.push_back('{we: 1'b0, idx: mIdx, data: mData});
      end
      if (reserveValid && reserveIndex != 5'd0) mBusy[reserveIndex] = 1'b1;
    end
    modelValid = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; reqValid = '0; reqIndex = '0; reqData = '0;
    reserveValid = 1'b0; reserveIndex = '0;
    for (int r = 0; r < 32; r++) regFile[r] = '0;

    tick(); tick();
    reset = 1'b1;
    repeat (5) tick();
    checkVal("idle_busy", busy, 32'd0);
    checkVal("idle_we", {31'b0, gprWriteEnable2}, 32'd0);
    checkVal("idle_ready", {29'b0, reqReady}, 32'd0);

    // ALU alone
    setReq(0, 1'b1, 5'd10, 32'h17171717);
    tick();
    reqValid = '0;
    checkVal("alu_we", {31'b0, gprWriteEnable2}, 32'd1);
    checkVal("alu_idx", {27'b0, gprIndex2}, 32'd10);
    checkVal("alu_data", gprWriteData2, 32'h17171717);
    tick(); tick();
    checkVal("gpr10", regFile[10], 32'h17171717);

    // restart from pointer 0, then all three contend
    reset = 1'b0; tick(); reset = 1'b1;
    setReq(0, 1'b1, 5'd3, 32'hA0A0A0A0);
    setReq(1, 1'b1, 5'd5, 32'hB1B1B1B1);
    setReq(2, 1'b1, 5'd7, 32'hC2C2C2C2);
    tick(); reqValid[0] = 1'b0;
    checkVal("rr0_idx", {27'b0, gprIndex2}, 32'd3);
    checkVal("rr0_we", {31'b0, gprWriteEnable2}, 32'd1);
    tick(); reqValid[1] = 1'b0;
    checkVal("rr1_idx", {27'b0, gprIndex2}, 32'd5);
    checkVal("rr1_we", {31'b0, gprWriteEnable2}, 32'd1);
    tick(); reqValid[2] = 1'b0;
    checkVal("rr2_idx", {27'b0, gprIndex2}, 32'd7);
    checkVal("rr2_we", {31'b0, gprWriteEnable2}, 32'd1);
    tick();
    checkVal("rr_done_we", {31'b0, gprWriteEnable2}, 32'd0);

    // load unit writes r0
    setReq(1, 1'b1, 5'd0, 32'hDEADBEEF);
    tick(); reqValid = '0;
    checkVal("r0_we", {31'b0, gprWriteEnable2}, 32'd0);
    checkVal("r0_busy0", {31'b0, busy[0]}, 32'd0);
    tick(); tick();
    checkVal("gpr0", regFile[0], 32'd0);

    // scoreboard set / set-vs-clear / clear
    reserveValid = 1'b1; reserveIndex = 5'd7;
    tick(); reserveValid = 1'b0;
    checkVal("rsv7", {31'b0, busy[7]}, 32'd1);
    reserveValid = 1'b1; reserveIndex = 5'd0;
    tick(); reserveValid = 1'b0;
    checkVal("rsv0", {31'b0, busy[0]}, 32'd0);
    reserveValid = 1'b1; reserveIndex = 5'd7;
    setReq(0, 1'b1, 5'd7, 32'h77777777);
    tick(); reserveValid = 1'b0; reqValid = '0;
    checkVal("set_wins", {31'b0, busy[7]}, 32'd1);
    checkVal("set_wins_we", {31'b0, gprWriteEnable2}, 32'd1);
    setReq(2, 1'b1, 5'd7, 32'h70707070);
    tick(); reqValid = '0;
    checkVal("clr7", {31'b0, busy[7]}, 32'd0);
    setReq(1, 1'b1, 5'd9, 32'h99999999);
    tick(); reqValid = '0;
    checkVal("clr_idle9", {31'b0, busy[9]}, 32'd0);

    // reset right after a transfer to r5
    reserveValid = 1'b1; reserveIndex = 5'd5; tick();
    reserveIndex = 5'd12; tick();
    reserveValid = 1'b0;
    setReq(1, 1'b1, 5'd5, 32'h55555555);
    tick();
    setReq(0, 1'b1, 5'd20, 32'h20202020);
    setReq(1, 1'b1, 5'd21, 32'h21212121);
    setReq(2, 1'b1, 5'd22, 32'h22222222);
    reset = 1'b0;
    tick();
    checkVal("rst_we", {31'b0, gprWriteEnable2}, 32'd0);
    checkVal("rst_busy", busy, 32'd0);
    reset = 1'b1;
    tick(); reqValid[0] = 1'b0;
    checkVal("rst_ptr_idx", {27'b0, gprIndex2}, 32'd20);
    reqValid = '0;
    tick();

    // randomized traffic with handshake-holding requesters
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (reqValid[i] && lastGrant[i]) reqValid[i] = 1'b0;
        if (!reqValid[i] && $urandom_range(0, 2) == 0)
          setReq(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      reserveValid = ($urandom_range(0, 3) == 0);
      reserveIndex = 5'($urandom_range(0, 31));
      tick();
    end
    reqValid = '0; reserveValid = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_writeback_arbiter.md
Name: gpr_writeback_arbiter

Overview:
- Shares the single write port of the general purpose register file (index2/writeData2/writeEnable2) among three writeback requesters: ALU, load unit, special/debug.
- Round-robin arbitration with valid/ready handshake, registered write stage, and r0 write suppression.
- Keeps a per-register busy scoreboard; decode uses it for hazard stalls.
- Sits between the execute/memory stages and GeneralPurposeRegisters.

Parameters:
- NUM_REQ, 3, number of writeback requesters; fixed at 3, index 0 = ALU, 1 = load, 2 = special.
- REG_COUNT, 32, number of GPRs; the index width is log2(REG_COUNT) = 5.
- DATA_WIDTH, 32, register width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset: sampled at the rising edge of clock, resets while 0.
- reqValid  in  NUM_REQ  per-requester write request valid.
- reqReady  out  NUM_REQ  per-requester accept; combinational, one-hot or zero.
- reqIndex  in  NUM_REQ*5  packed destination register per requester; requester i in bits [5i+4:5i].
- reqData  in  NUM_REQ*32  packed write data per requester; requester i in bits [32i+31:32i].
- reserveValid  in  1  mark a destination register busy (issue of a writing instruction).
- reserveIndex  in  5  register to mark busy.
- gprIndex2  out  5  drives GPR index2.
- gprWriteData2  out  32  drives GPR writeData2.
- gprWriteEnable2  out  1  drives GPR writeEnable2.
- busy  out  32  scoreboard; bit n = register n has an outstanding write.

Behaviour:
- Reset (reset==0 at an edge): gprIndex2=0, gprWriteData2=0, gprWriteEnable2=0, busy=0, round-robin pointer=0. Stats counters are cleared when built in. reqReady is forced to 0 while reset==0.
- Arbitration:
  - Each cycle the winner is the first requester with reqValid=1, searching from the pointer upward and wrapping (pointer, pointer+1, ..., mod NUM_REQ).
  - reqReady is 1 only for the winner.
  - Transfer happens at an edge with valid&ready.
- Pointer update: after a transfer by requester i, pointer = (i+1) mod NUM_REQ. The pointer is unchanged in cycles with no transfer.
- Handshake rule: a requester holds valid/index/data stable until ready. Deasserting valid without a transfer is permitted. The arbiter keeps no state per pending request.
- Write stage: a transfer at edge k registers index/data into the gpr* outputs. gprWriteEnable2=1 for exactly the cycle after edge k, unless index==0. The GPR captures the data at edge k+1, so the total latency from accept to register update is 2 edges.
- Idle: with no transfer at an edge, gprWriteEnable2=0 in the following cycle. gprIndex2 and gprWriteData2 hold their last values.
- r0: a transfer to index 0 is accepted normally (ready asserted, pointer advances). gprWriteEnable2 stays 0 and busy[0] is unaffected.
- Scoreboard:
  - Set: reserveValid=1 with reserveIndex!=0 sets busy[reserveIndex] at the edge.
  - Clear: a transfer to index n (n!=0) clears busy[n] at the acceptance edge.
  - busy[0] is constant 0.
  - Set and clear of the same index at the same edge: set wins (a newer instruction owns the register).
  - Reserving an already-busy register: stays busy, no error.
  - Clearing a non-busy register: stays 0.
- Back-to-back: a new transfer every cycle is allowed. gprWriteEnable2 stays high on consecutive cycles, with index/data updated each edge.
- Reset mid-operation: an in-flight registered write is dropped; gprWriteEnable2=0 in the next cycle.

Optional Feature:
- Macro: GPR_WRITEBACK_ARBITER_STATS_EN.
- When defined:
  - Adds output grantCount (NUM_REQ*16): per-requester 16-bit saturating counters, each incremented on that requester's transfer.
  - Adds output conflictCount (16): saturating, incremented in every cycle where more than one reqValid is 1.
  - Saturation: counters stop at 16'hFFFF.
- When undefined: these ports and registers are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package/include:
  - Requester id constants REQ_ALU=0, REQ_LOAD=1, REQ_SPECIAL=2.
  - GPR_INDEX_WIDTH=5, GPR_DATA_WIDTH=32, REG_ZERO=0.
- Sub-module round_robin_arbiter:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, winner index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset, then reqValid=3'b000 for 5 cycles -> busy=0, gprWriteEnable2=0, reqReady=0.
- Only ALU valid, index 10, data 32'h17171717 -> reqReady=3'b001. In the next cycle gprIndex2=10, gprWriteData2=32'h17171717, gprWriteEnable2=1. The GPR cell 10 reads back 32'h17171717 afterwards.
- All three valid with indices 3/5/7, held for 3 cycles -> grants in order 0,1,2. gprWriteEnable2 is high for 3 consecutive cycles with indices 3,5,7.
- Load unit writes index 0 with data 32'hDEADBEEF -> reqReady[1]=1, gprWriteEnable2 stays 0, GPR cell 0 unchanged, busy[0]=0.
- reserveValid with index 7 -> busy[7]=1. Later, reserve 7 and transfer to 7 at the same edge -> busy[7] stays 1; a further transfer to 7 -> busy[7]=0.
- Reset asserted (reset=0) in the cycle after a transfer to index 5 -> gprWriteEnable2=0 after the reset edge, busy=0, next arbitration starts at requester 0.
